// File: rtl/scan_chain_ctrl_if.sv
// Bundle of the host handshake and the two-chain scan signals of scan_chain_ctrl.
// slave is the controller's view; master is the host/core-model side.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 15
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pat_a;
  logic [CHAIN_LEN-1:0] pat_b;
  logic [CHAIN_LEN-1:0] exp_a;
  logic [CHAIN_LEN-1:0] exp_b;
  logic                 so1;
  logic                 so2;
  logic                 si1;
  logic                 si2;
  logic                 se;
  logic                 test_mode;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] resp_a;
  logic [CHAIN_LEN-1:0] resp_b;
  logic                 fail;

  modport slave (
    input  start, pat_a, pat_b, exp_a, exp_b, so1, so2,
    output si1, si2, se, test_mode, busy, done, resp_a, resp_b, fail
  );

  modport master (
    output start, pat_a, pat_b, exp_a, exp_b, so1, so2,
    input  si1, si2, se, test_mode, busy, done, resp_a, resp_b, fail
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Two-chain scan controller: load one pattern per chain, one capture cycle,
// unload and compare the response. All outputs are registered.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 15
) (
  input  logic              clk,
  input  logic              reset,
  scan_chain_ctrl_if.slave  bus
);
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, DONE} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CHAIN_LEN-1:0] pat_a_reg, pat_b_reg, exp_a_reg, exp_b_reg;
  logic [CHAIN_LEN-1:0] resp_a_next, resp_b_next;

  // Response including the bit sampled at the edge closing this cycle, so the
  // final compare sees the completed unload.
  always_comb begin
    resp_a_next = bus.resp_a;
    resp_b_next = bus.resp_b;
    if (state_reg == UNLOAD) begin
      resp_a_next[cnt_reg] = bus.so1;
      resp_b_next[cnt_reg] = bus.so2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pat_a_reg     <= '0;
      pat_b_reg     <= '0;
      exp_a_reg     <= '0;
      exp_b_reg     <= '0;
      bus.si1       <= 1'b0;
      bus.si2       <= 1'b0;
      bus.se        <= 1'b0;
      bus.test_mode <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.resp_a    <= '0;
      bus.resp_b    <= '0;
      bus.fail      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            pat_a_reg     <= bus.pat_a;
            pat_b_reg     <= bus.pat_b;
            exp_a_reg     <= bus.exp_a;
            exp_b_reg     <= bus.exp_b;
            bus.resp_a    <= '0;
            bus.resp_b    <= '0;
            bus.fail      <= 1'b0;
            cnt_reg       <= LAST;
            // First shift bit goes out straight from the inputs being snapshotted.
            bus.si1       <= bus.pat_a[CHAIN_LEN-1];
            bus.si2       <= bus.pat_b[CHAIN_LEN-1];
            bus.se        <= 1'b1;
            bus.test_mode <= 1'b1;
            bus.busy      <= 1'b1;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_reg == '0) begin
            bus.si1   <= 1'b0;
            bus.si2   <= 1'b0;
            bus.se    <= 1'b0;
            state_reg <= CAPTURE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
            bus.si1 <= pat_a_reg[cnt_reg - 1'b1];
            bus.si2 <= pat_b_reg[cnt_reg - 1'b1];
          end
        end
        CAPTURE: begin
          cnt_reg   <= LAST;
          bus.se    <= 1'b1;
          state_reg <= UNLOAD;
        end
        UNLOAD: begin
          bus.resp_a <= resp_a_next;
          bus.resp_b <= resp_b_next;
          if (cnt_reg == '0) begin
            bus.se        <= 1'b0;
            bus.test_mode <= 1'b0;
            bus.done      <= 1'b1;
            bus.fail      <= (resp_a_next != exp_a_reg) || (resp_b_next != exp_b_reg);
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          bus.done  <= 1'b0;
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Two-chain scan test controller that drives the scan ports of the core datapath (si1, si2, se, test_mode) and consumes its scan outputs (so1, so2). It sits directly upstream and downstream of the core's two scan chains: it loads one pattern per chain, issues a single capture cycle, unloads the response, and compares it against expected data. Each chain is 15 flops by default: 10 in the 20-bit pipeline register followed by 5 in the 10-bit pipeline register.

## Interface

**Parameters**
- CHAIN_LEN, default 15: flops per scan chain; both chains are equal length.

**Ports**
- clk  in  1  single clock, shared with the core under test.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one load/capture/unload pass; honoured only in IDLE.
- pat_a  in  CHAIN_LEN  load pattern for chain 1; bit k lands in flop k, where flop 0 is nearest si1.
- pat_b  in  CHAIN_LEN  load pattern for chain 2, same bit mapping.
- exp_a  in  CHAIN_LEN  expected captured contents of chain 1.
- exp_b  in  CHAIN_LEN  expected captured contents of chain 2.
- so1  in  1  scan out of chain 1, from the core.
- so2  in  1  scan out of chain 2, from the core.
- si1  out  1  scan in of chain 1, registered.
- si2  out  1  scan in of chain 2, registered.
- se  out  1  scan enable, registered.
- test_mode  out  1  test-mode select to the core, registered.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- resp_a  out  CHAIN_LEN  unloaded chain 1 response; resp_a[k] is the value flop k captured.
- resp_b  out  CHAIN_LEN  unloaded chain 2 response, same bit mapping.
- fail  out  1  response mismatch flag; valid with done and held until the next accepted start.

## Operation

**States:** IDLE, SHIFT, CAPTURE, UNLOAD, DONE.

**IDLE**
- se = 0, si1 = si2 = 0, test_mode = 0.
- When start = 1, snapshot pat_a, pat_b, exp_a and exp_b into internal registers, clear fail and resp_a/resp_b, load the counter with CHAIN_LEN-1, and go to SHIFT.

**SHIFT** (CHAIN_LEN cycles)
- se = 1, test_mode = 1.
- Drive si1/si2 from the MSB of the pattern snapshot first (bit CHAIN_LEN-1 first, bit 0 last).
- Decrement the counter each cycle; at 0 go to CAPTURE.

**CAPTURE** (1 cycle)
- se = 0, test_mode = 1; the core loads its functional D inputs.
- Reload the counter with CHAIN_LEN-1 and go to UNLOAD.

**UNLOAD** (CHAIN_LEN cycles)
- se = 1, test_mode = 1, si1 = si2 = 0.
- Unload cycle j (j = 0..CHAIN_LEN-1) samples so1/so2 at its closing edge into resp_a/resp_b[CHAIN_LEN-1-j].
- At counter 0 go to DONE.

**DONE** (1 cycle)
- done = 1, se = 0, test_mode = 0.
- fail = (resp_a != exp_a) | (resp_b != exp_b), computed from the completed response.
- Go to IDLE.

**Rules**
- start outside IDLE is ignored, with no queuing. start held high re-triggers on the cycle after DONE, once the FSM is back in IDLE.
- Input changes after acceptance have no effect on the current pass.
- The counter width is $clog2(CHAIN_LEN); with the default it is 4 bits, and it never wraps below 0.
- resp_a/resp_b are cleared at acceptance of start. They update only in UNLOAD and are stable from DONE until the next accepted start.

## Timing

- All outputs are registered; there is no combinational path from so1/so2 to any output.
- Reset value of every output is 0: si1, si2, se, test_mode, busy, done, resp_a, resp_b, fail.
- Reset asserted mid-pass forces IDLE immediately and asynchronously with all outputs at 0. The core chains are left in an undefined state, and the next pass reloads them fully.
- Cycle-level sequence, with the start-sampling edge as edge 0:
  - Outputs reflect SHIFT during cycles 1..L (L = CHAIN_LEN).
  - CAPTURE is cycle L+1.
  - UNLOAD spans cycles L+2..2L+1.
  - done is high in cycle 2L+2.
  - busy is low again from cycle 2L+3.
- Pass latency is 2L+2 cycles (32 for the default). The minimum start-to-start spacing is 2L+3 cycles.
- so1/so2 are sampled at the rising edge closing each UNLOAD cycle. The core's scan flops update on that same edge, so the sample is the pre-edge flop value.

## Test plan

- **Reset:** assert reset mid-SHIFT (cycle 5) -> all outputs 0 on the same cycle; busy stays 0 until the next start.
- **Shift order:** bench models both chains as 15-bit shift registers whose capture holds their contents; pat_a=15'h2AAA, pat_b=15'h1555, exp equal to pat -> done at cycle 32, resp_a=15'h2AAA, resp_b=15'h1555, fail=0.
- **Capture path:** bench capture loads 15'h7F00 into chain 1 and 15'h00FF into chain 2, exp_a=15'h7F00, exp_b=15'h00FF -> fail=0. Repeat with exp_b=15'h00FE -> fail=1.
- **Busy handling:** start held high continuously -> start re-triggers only on the cycle after DONE, once back in IDLE; start pulse at cycle 10 of a pass ignored; pat_a changed at cycle 3 -> resp still matches the snapshot.
- **Control waveform:** check se=1 for cycles 1-15, 0 at 16, 1 for 17-31, 0 at 32; test_mode=1 for cycles 1-31; si1/si2=0 during UNLOAD.
- **Parameter:** CHAIN_LEN=5 with loopback bench, pat_a=5'b10011 -> resp_a=5'b10011, done at cycle 12.
